// File: rtl/smallseg_g0table_update_ctrl_if.sv
// Command/response handshake plus single-port table bus for one G0 rule table.
// slave = update controller view, master = host and block RAM view.
interface smallseg_g0table_update_ctrl_if #(
  parameter int unsigned ENTRY_W = 171,
  parameter int unsigned ADDR_W  = 11
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [ADDR_W-1:0]  cmd_index;
  logic [10:0]        cmd_rule_id;
  logic [ENTRY_W-1:0] cmd_entry;

  logic               resp_valid;
  logic               resp_ready;
  logic               resp_hit;
  logic [ADDR_W-1:0]  resp_index;
  logic [ENTRY_W-1:0] resp_data;

  logic [ADDR_W-1:0]  tbl_addr;
  logic [ENTRY_W-1:0] tbl_din;
  logic               tbl_we;
  logic [ENTRY_W-1:0] tbl_dout;

  modport master (
    output cmd_valid, cmd_op, cmd_index, cmd_rule_id, cmd_entry, resp_ready, tbl_dout,
    input  cmd_ready, resp_valid, resp_hit, resp_index, resp_data, tbl_addr, tbl_din, tbl_we
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_index, cmd_rule_id, cmd_entry, resp_ready, tbl_dout,
    output cmd_ready, resp_valid, resp_hit, resp_index, resp_data, tbl_addr, tbl_din, tbl_we
  );
endinterface

// File: rtl/smallseg_g0table_update_ctrl.sv
// Update/lookup controller for one small-segment/G0 rule table: READ, WRITE,
// DELETE-by-ruleID and INSERT-into-first-empty over a single-port block RAM.
module smallseg_g0table_update_ctrl #(
  parameter int unsigned TABLE_ENTRY_SIZE = 1738,
  parameter int unsigned ENTRY_W          = 171,
  parameter int unsigned ADDR_W           = 11,
  parameter logic [10:0] EMPTY_ID         = 11'h7FF
) (
  input logic clk,
  input logic rst_n,
  smallseg_g0table_update_ctrl_if.slave io_bus
);
  localparam logic [1:0] OpRead   = 2'd0;
  localparam logic [1:0] OpWrite  = 2'd1;
  localparam logic [1:0] OpDelete = 2'd2;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(TABLE_ENTRY_SIZE);

  typedef enum logic [2:0] {StIdle, StRdIssue, StRdCapt, StScan, StWr, StResp} state_e;

  state_e r_state, w_state_d;

  logic [1:0]         r_op, w_op_d;
  logic [ADDR_W-1:0]  r_index, w_index_d;
  logic [10:0]        r_rule_id, w_rule_id_d;
  logic [ENTRY_W-1:0] r_entry, w_entry_d;

  logic [ADDR_W-1:0]  r_tbl_addr, w_tbl_addr_d;
  logic [ENTRY_W-1:0] r_tbl_din, w_tbl_din_d;
  logic               r_tbl_we, w_tbl_we_d;

  logic               r_resp_valid, w_resp_valid_d;
  logic               r_resp_hit, w_resp_hit_d;
  logic [ADDR_W-1:0]  r_resp_index, w_resp_index_d;
  logic [ENTRY_W-1:0] r_resp_data, w_resp_data_d;

  // Scan pipeline: issue -> dout pending for r_daddr -> registered compare stage.
  logic               r_issuing, w_issuing_d;
  logic               r_pend, w_pend_d;
  logic [ADDR_W-1:0]  r_daddr, w_daddr_d;
  logic               r_cmp_v, w_cmp_v_d;
  logic [ADDR_W-1:0]  r_cmp_addr, w_cmp_addr_d;
  logic [ENTRY_W-1:0] r_cmp_data, w_cmp_data_d;

  logic [10:0]        w_key;
  logic               w_match;
  logic               w_scan_done;
  logic               w_cmd_in_range;
  logic [ENTRY_W-1:0] w_ins_entry;
  logic [ENTRY_W-1:0] w_del_entry;

  assign w_key          = (r_op == OpDelete) ? r_rule_id : EMPTY_ID;
  assign w_match        = r_cmp_v && (r_cmp_data[21:11] == w_key);
  assign w_scan_done    = !r_issuing && !r_pend && !r_cmp_v;
  assign w_cmd_in_range = (io_bus.cmd_index <= LastAddr);
  assign w_ins_entry    = {r_entry[ENTRY_W-1:11], 11'(r_cmp_addr)};
  assign w_del_entry    = ENTRY_W'({EMPTY_ID, 11'd0});

  assign io_bus.cmd_ready  = (r_state == StIdle);
  assign io_bus.resp_valid = r_resp_valid;
  assign io_bus.resp_hit   = r_resp_hit;
  assign io_bus.resp_index = r_resp_index;
  assign io_bus.resp_data  = r_resp_data;
  assign io_bus.tbl_addr   = r_tbl_addr;
  assign io_bus.tbl_din    = r_tbl_din;
  assign io_bus.tbl_we     = r_tbl_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (io_bus.cmd_valid) begin
          unique case (io_bus.cmd_op)
            OpRead:   w_state_d = StRdIssue;
            OpWrite:  w_state_d = w_cmd_in_range ? StWr : StResp;
            OpDelete: w_state_d = (io_bus.cmd_rule_id == EMPTY_ID) ? StResp : StScan;
            default:  w_state_d = StScan;
          endcase
        end
      end
      StRdIssue: w_state_d = StRdCapt;
      StRdCapt:  w_state_d = StResp;
      StScan: begin
        if (w_match) begin
          w_state_d = StWr;
        end else if (w_scan_done) begin
          w_state_d = StResp;
        end
      end
      StWr:   w_state_d = StResp;
      StResp: if (io_bus.resp_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_op_d         = r_op;
    w_index_d      = r_index;
    w_rule_id_d    = r_rule_id;
    w_entry_d      = r_entry;
    w_tbl_addr_d   = r_tbl_addr;
    w_tbl_din_d    = r_tbl_din;
    w_tbl_we_d     = 1'b0;
    w_resp_valid_d = r_resp_valid;
    w_resp_hit_d   = r_resp_hit;
    w_resp_index_d = r_resp_index;
    w_resp_data_d  = r_resp_data;
    w_issuing_d    = r_issuing;
    w_pend_d       = 1'b0;
    w_daddr_d      = r_daddr;
    w_cmp_v_d      = 1'b0;
    w_cmp_addr_d   = r_cmp_addr;
    w_cmp_data_d   = r_cmp_data;
    unique case (r_state)
      StIdle: begin
        if (io_bus.cmd_valid) begin
          w_op_d       = io_bus.cmd_op;
          w_index_d    = io_bus.cmd_index;
          w_rule_id_d  = io_bus.cmd_rule_id;
          w_entry_d    = io_bus.cmd_entry;
          w_tbl_addr_d = '0;
          unique case (io_bus.cmd_op)
            OpRead: w_tbl_addr_d = io_bus.cmd_index;
            OpWrite: begin
              if (w_cmd_in_range) begin
                w_tbl_addr_d = io_bus.cmd_index;
                w_tbl_din_d  = io_bus.cmd_entry;
                w_tbl_we_d   = 1'b1;
              end else begin
                w_resp_valid_d = 1'b1;
                w_resp_hit_d   = 1'b0;
                w_resp_index_d = io_bus.cmd_index;
                w_resp_data_d  = io_bus.cmd_entry;
              end
            end
            OpDelete: begin
              // The empty marker is never a real rule, so skip the scan.
              if (io_bus.cmd_rule_id == EMPTY_ID) begin
                w_resp_valid_d = 1'b1;
                w_resp_hit_d   = 1'b0;
                w_resp_index_d = '0;
                w_resp_data_d  = '0;
              end else begin
                w_issuing_d = 1'b1;
              end
            end
            default: w_issuing_d = 1'b1;
          endcase
        end
      end
      StRdIssue: ;
      StRdCapt: begin
        w_resp_valid_d = 1'b1;
        w_resp_hit_d   = 1'b1;
        w_resp_index_d = r_index;
        w_resp_data_d  = io_bus.tbl_dout;
      end
      StScan: begin
        if (w_match) begin
          w_issuing_d    = 1'b0;
          w_tbl_we_d     = 1'b1;
          w_tbl_addr_d   = r_cmp_addr;
          w_tbl_din_d    = (r_op == OpDelete) ? w_del_entry : w_ins_entry;
          w_resp_hit_d   = 1'b1;
          w_resp_index_d = r_cmp_addr;
          w_resp_data_d  = (r_op == OpDelete) ? r_cmp_data : w_ins_entry;
        end else if (w_scan_done) begin
          w_resp_valid_d = 1'b1;
          w_resp_hit_d   = 1'b0;
          w_resp_index_d = LastAddr;
          w_resp_data_d  = '0;
        end else begin
          w_pend_d     = r_issuing;
          w_daddr_d    = r_tbl_addr;
          w_cmp_v_d    = r_pend;
          w_cmp_addr_d = r_daddr;
          w_cmp_data_d = io_bus.tbl_dout;
          if (r_issuing) begin
            if (r_tbl_addr == LastAddr) begin
              w_issuing_d = 1'b0;
            end else begin
              w_tbl_addr_d = r_tbl_addr + 1'b1;
            end
          end
        end
      end
      StWr: begin
        w_resp_valid_d = 1'b1;
        if (r_op == OpWrite) begin
          w_resp_hit_d   = 1'b1;
          w_resp_index_d = r_index;
          w_resp_data_d  = r_entry;
        end
      end
      StResp: if (io_bus.resp_ready) w_resp_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= '0;
      r_index      <= '0;
      r_rule_id    <= '0;
      r_entry      <= '0;
      r_tbl_addr   <= '0;
      r_tbl_din    <= '0;
      r_tbl_we     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_index <= '0;
      r_resp_data  <= '0;
      r_issuing    <= 1'b0;
      r_pend       <= 1'b0;
      r_daddr      <= '0;
      r_cmp_v      <= 1'b0;
      r_cmp_addr   <= '0;
      r_cmp_data   <= '0;
    end else begin
      r_op         <= w_op_d;
      r_index      <= w_index_d;
      r_rule_id    <= w_rule_id_d;
      r_entry      <= w_entry_d;
      r_tbl_addr   <= w_tbl_addr_d;
      r_tbl_din    <= w_tbl_din_d;
      r_tbl_we     <= w_tbl_we_d;
      r_resp_valid <= w_resp_valid_d;
      r_resp_hit   <= w_resp_hit_d;
      r_resp_index <= w_resp_index_d;
      r_resp_data  <= w_resp_data_d;
      r_issuing    <= w_issuing_d;
      r_pend       <= w_pend_d;
      r_daddr      <= w_daddr_d;
      r_cmp_v      <= w_cmp_v_d;
      r_cmp_addr   <= w_cmp_addr_d;
      r_cmp_data   <= w_cmp_data_d;
    end
  end
endmodule
